trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Sits directly upstream of the machine-mode CSR file.
- Decides when a trap (ecall, timer interrupt, external interrupt) or an mret is taken, and supplies the CSR file with its trap strobe, cause and return PC.
- Redirects fetch to the trap vector or to mepc, and stalls the pipeline while it sequences.
- Owns the machine timer (64-bit mtime/mtimecmp) and produces the MTIP/MEIP pending bits consumed as mip.

Parameters:
- MTIME_DIV, 1: mtime increments once every MTIME_DIV clocks. Legal range 1..255.
- RESET_VEC, 32'h0000_0000: redirect_pc value out of reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset_x  input  1  asynchronous, active-low reset.
- instr_valid  input  1  decode holds a valid instruction at pc.
- pc  input  32  PC of the instruction in decode.
- ecall  input  1  decoded ecall; qualified by instr_valid.
- mret  input  1  decoded mret; qualified by instr_valid.
- mstatus_mie  input  1  mstatus[3].
- mie_in  input  32  current mie; bits 7 (MTIE) and 11 (MEIE) are used.
- mtvec_in  input  32  current mtvec.
- mepc_in  input  32  current mepc.
- ext_irq  input  1  level-sensitive external interrupt, synchronous to clk.
- tmr_we  input  1  timer register write strobe.
- tmr_addr  input  2  0 = mtimecmp lo, 1 = mtimecmp hi, 2 = mtime lo, 3 = mtime hi.
- tmr_wdata  input  32  timer write data.
- tmr_rdata  output  32  combinational read of the register at tmr_addr.
- trap_take  output  1  one-cycle strobe to the CSR file: latch trap_epc/trap_cause, clear MIE.
- trap_cause  output  32  mcause value; valid while trap_take is high.
- trap_epc  output  32  mepc value; valid while trap_take is high.
- mret_take  output  1  one-cycle strobe to the CSR file: restore MIE.
- redirect  output  1  one-cycle fetch redirect.
- redirect_pc  output  32  redirect target.
- stall  output  1  freezes decode and earlier stages.
- mip_out  output  32  bit 7 = MTIP, bit 11 = MEIP, all other bits 0.

Behaviour:
- Reset values: FSM = IDLE; trap_take, mret_take, redirect, stall = 0; trap_cause = 0; trap_epc = 0; redirect_pc = RESET_VEC; mtime = 0; mtimecmp = all ones; prescaler = 0.
- FSM states: IDLE, ENTER, RETURN, REDIR.
- IDLE, event selection (only when instr_valid = 1, fixed priority):
  1. MEI: mstatus_mie & mie_in[11] & ext_irq.
  2. MTI: mstatus_mie & mie_in[7] & MTIP.
  3. ecall.
  4. mret.
- IDLE, interrupt or ecall selected:
  - Register cause: MEI = 32'h8000_000B, MTI = 32'h8000_0007, ecall = 32'd11.
  - Register epc = pc.
  - Go to ENTER.
- IDLE, mret selected: go to RETURN.
- IDLE, stall = 0. In every other state, stall = 1.
- ENTER: trap_take = 1 for exactly one cycle; go to REDIR with target = mtvec_in & ~32'h3.
- RETURN: mret_take = 1 for exactly one cycle; go to REDIR with target = mepc_in.
- REDIR: redirect = 1 for one cycle with redirect_pc = the registered target; go to IDLE.
- Latency: the event is seen in IDLE at cycle N; trap_take/mret_take at N+1; redirect at N+2; stall high on N+1 and N+2.
- ecall and mret asserted together: ecall wins.
- ecall/mret/interrupts arriving while not in IDLE are ignored. The stall holds decode, so the event is re-evaluated on return to IDLE.
- Interrupt with instr_valid = 0: not taken until instr_valid = 1.
- Timer:
  - Prescaler counts 0..MTIME_DIV-1; mtime increments by 1 on wrap. Wrap-around 2^64-1 → 0 is permitted.
  - tmr_we to mtime lo/hi replaces that half and suppresses the increment in that cycle.
  - Writes to mtimecmp do not affect the prescaler.
- MTIP = (mtime >= mtimecmp), unsigned 64-bit compare, registered. It reflects a write on the cycle after the write.
- MEIP = ext_irq registered once.
- Reset asserted mid-sequence returns to IDLE immediately and drops all strobes in the same instant.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if mtvec_in[1:0] = 2'b01 and the trap is an interrupt, target = (mtvec_in & ~3) + 4 × cause[4:0]. Exceptions (ecall) always use the base.
- Undefined: mtvec_in[1:0] is ignored and every trap uses the base (direct mode).

Test Plan:
- ecall at pc = 32'h100, mtvec = 32'h200 → trap_take at N+1 with trap_cause = 11 and trap_epc = 32'h100; redirect at N+2 to 32'h200; stall high on N+1 and N+2.
- mret with mepc = 32'h104 → mret_take at N+1, redirect to 32'h104 at N+2, no trap_take.
- mtimecmp = 5, MTIME_DIV = 1, MIE = 1, MTIE = 1, reset then run → MTIP rises once mtime reaches 5; trap_cause = 32'h8000_0007; no trap while mstatus_mie = 0.
- ext_irq, MTIP and ecall all active in the same cycle → cause 32'h8000_000B. After mret, MTI is taken next with cause 32'h8000_0007.
- With TRAP_VECTORED_EN defined and mtvec = 32'h301: MTI redirects to 32'h31C, ecall redirects to 32'h300. Without the macro, both redirect to 32'h300.
- reset_x pulsed low during ENTER → trap_take, stall and redirect are 0 immediately; redirect_pc = RESET_VEC; mtime = 0; mtimecmp = all ones.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Bus between the decode/CSR side of the core and trap_sequencer.
// master = core side (drives decode, CSR and timer-bus inputs).
// slave  = trap_sequencer.
interface trap_sequencer_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic        ecall;
  logic        mret;
  logic        mstatus_mie;
  logic [31:0] mie_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        ext_irq;
  logic        tmr_we;
  logic [1:0]  tmr_addr;
  logic [31:0] tmr_wdata;
  logic [31:0] tmr_rdata;
  logic        trap_take;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        mret_take;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] mip_out;

  modport master (
    output instr_valid, pc, ecall, mret, mstatus_mie, mie_in, mtvec_in, mepc_in,
           ext_irq, tmr_we, tmr_addr, tmr_wdata,
    input  tmr_rdata, trap_take, trap_cause, trap_epc, mret_take, redirect,
           redirect_pc, stall, mip_out
  );

  modport slave (
    input  instr_valid, pc, ecall, mret, mstatus_mie, mie_in, mtvec_in, mepc_in,
           ext_irq, tmr_we, tmr_addr, tmr_wdata,
    output tmr_rdata, trap_take, trap_cause, trap_epc, mret_take, redirect,
           redirect_pc, stall, mip_out
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap / mret sequencer and machine timer in front of the M-mode CSR file.
// Optional build macro TRAP_VECTORED_EN: vectored interrupt targets when
// mtvec mode is 2'b01; otherwise every trap goes to the mtvec base.
//
// state  | meaning
// IDLE   | watching decode for interrupt / ecall / mret
// ENTER  | trap_take strobe to CSR file, latch trap target
// RETURN | mret_take strobe to CSR file, latch mepc as target
// REDIR  | redirect fetch to the latched target
module trap_sequencer #(
  parameter int unsigned MTIME_DIV = 1,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset_x,
  trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENTER, RETURN, REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] trap_target;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]  presc_q;
  logic        tick;
  logic        mtip_q, meip_q;
  logic        mei_evt, mti_evt;
  logic        trap_take, mret_take, redirect, stall;
  logic        unused_bits;

  assign tick    = (presc_q == 8'(MTIME_DIV - 1));
  assign mei_evt = bus.mstatus_mie & bus.mie_in[11] & bus.ext_irq;
  assign mti_evt = bus.mstatus_mie & bus.mie_in[7] & mtip_q;

  // Prescaler: free-running 0..MTIME_DIV-1, unaffected by register writes.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) presc_q <= '0;
    else          presc_q <= tick ? 8'd0 : presc_q + 8'd1;
  end

  // Next timer values: a write to an mtime half replaces it and skips the tick.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (bus.tmr_we) begin
      case (bus.tmr_addr)
        2'd0: mtimecmp_d[31:0]  = bus.tmr_wdata;
        2'd1: mtimecmp_d[63:32] = bus.tmr_wdata;
        2'd2: mtime_d = {mtime_q[63:32], bus.tmr_wdata};
        default: mtime_d = {bus.tmr_wdata, mtime_q[31:0]};
      endcase
    end
  end

  // Timer registers; MTIP compares the next values so a write shows one cycle later.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_d >= mtimecmp_d);
      meip_q     <= bus.ext_irq;
    end
  end

  // Timer register read mux.
  always_comb begin
    case (bus.tmr_addr)
      2'd0:    bus.tmr_rdata = mtimecmp_q[31:0];
      2'd1:    bus.tmr_rdata = mtimecmp_q[63:32];
      2'd2:    bus.tmr_rdata = mtime_q[31:0];
      default: bus.tmr_rdata = mtime_q[63:32];
    endcase
  end

  // Trap target from mtvec; vectoring only applies to interrupts (cause[31]).
  always_comb begin
    trap_target = bus.mtvec_in & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (bus.mtvec_in[1:0] == 2'b01 && cause_q[31])
      trap_target = (bus.mtvec_in & ~32'h3) + {25'd0, cause_q[4:0], 2'b00};
`endif
  end

  // FSM state and latched trap context.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= RESET_VEC;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  // FSM next state and strobes; event priority MEI > MTI > ecall > mret.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    target_d  = target_q;
    trap_take = 1'b0;
    mret_take = 1'b0;
    redirect  = 1'b0;
    stall     = 1'b1;
    case (state_q)
      IDLE: begin
        stall = 1'b0;
        if (bus.instr_valid) begin
          if (mei_evt) begin
            cause_d = 32'h8000_000B;
            epc_d   = bus.pc;
            state_d = ENTER;
          end else if (mti_evt) begin
            cause_d = 32'h8000_0007;
            epc_d   = bus.pc;
            state_d = ENTER;
          end else if (bus.ecall) begin
            cause_d = 32'd11;
            epc_d   = bus.pc;
            state_d = ENTER;
          end else if (bus.mret) begin
            state_d = RETURN;
          end
        end
      end
      ENTER: begin
        trap_take = 1'b1;
        target_d  = trap_target;
        state_d   = REDIR;
      end
      RETURN: begin
        mret_take = 1'b1;
        target_d  = bus.mepc_in;
        state_d   = REDIR;
      end
      REDIR: begin
        redirect = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.trap_take   = trap_take;
  assign bus.mret_take   = mret_take;
  assign bus.redirect    = redirect;
  assign bus.stall       = stall;
  assign bus.trap_cause  = cause_q;
  assign bus.trap_epc    = epc_q;
  assign bus.redirect_pc = target_q;
  assign bus.mip_out     = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};

  assign unused_bits = ^{bus.mie_in[31:12], bus.mie_in[10:8], bus.mie_in[6:0],
                         bus.mtvec_in[1:0]};

endmodule
